// File: rtl/irq_sched_pkg.sv
// Shared definitions for the interrupt scheduler: register word offsets,
// FSM state encoding, vector width and the IVR word formatter.
package irq_sched_pkg;

  // Width of the vector field reported in IVR (supports up to 16 sources).
  localparam int VEC_W = 4;

  // Register word offsets, decoded from addr[3:2].
  localparam logic [1:0] IRQ_RAW = 2'd0;
  localparam logic [1:0] IRQ_IER = 2'd1;
  localparam logic [1:0] IRQ_IPR = 2'd2;
  localparam logic [1:0] IRQ_IVR = 2'd3;

  // Service state: IDLE looks for a candidate, ACTIVE holds one until EOI.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // IVR layout: valid in bit 31, vector in the low nibble, zeros between.
  function automatic logic [31:0] ivr_word(input logic valid,
                                           input logic [VEC_W-1:0] vec);
    return {valid, {(31-VEC_W){1'b0}}, vec};
  endfunction

endpackage

// File: rtl/irq_sched_if.sv
// CPU-side register bus of the interrupt scheduler: a write channel with
// byte strobes and a read channel whose data is returned combinationally.
interface irq_sched_if;

  logic [3:0]  wr_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [3:0]  rd_addr;
  logic        rd_en;
  logic [31:0] rd_data;

  // The CPU bridge drives requests and samples read data.
  modport master (
    output wr_addr, wr_en, wr_data, wr_strb, rd_addr, rd_en,
    input  rd_data
  );

  // The scheduler accepts requests and returns read data.
  modport slave (
    input  wr_addr, wr_en, wr_data, wr_strb, rd_addr, rd_en,
    output rd_data
  );

endinterface

// File: rtl/irq_sched_prio_enc.sv
// Fixed-priority encoder: reports the lowest set request index and whether
// any request is set. Purely combinational so it can be reused by a
// second-level scheduler later.
module prio_enc
  import irq_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  output logic [VEC_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set index is written last and wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = VEC_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_sched.sv
// Memory-mapped interrupt scheduler for the MicroBlaze snake SoC.
// Latches peripheral interrupt lines as pending, picks the lowest-index
// enabled pending source, raises irq_out and holds that source in service
// until software acknowledges it with an EOI write to IVR (no nesting).
//
// Build option: define IRQ_SCHED_AUTOACK_EN to make an IVR read while a
// source is in service act as the EOI in the same cycle.
module irq_sched
  import irq_sched_pkg::*;
#(
  parameter int          N_SRC     = 4,
  // Per-source mode, bit=1 rising-edge, bit=0 level. Bits >= N_SRC unused.
  parameter logic [15:0] EDGE_MASK = 16'h000F
) (
  input  logic             clk,
  input  logic             rst,
  irq_sched_if.slave       bus,
  input  logic [N_SRC-1:0] src_in,
  output logic             irq_out
);

  localparam logic [N_SRC-1:0] EDGE_SRC = EDGE_MASK[N_SRC-1:0];

  // Register state.
  logic [N_SRC-1:0] src_d;
  logic [N_SRC-1:0] ier;
  logic [N_SRC-1:0] ipr;
  logic [N_SRC-1:0] ipr_n;
  logic [VEC_W-1:0] vec;
  state_t           state;
  state_t           state_n;

  // Decoded bus requests.
  logic             wr_ok;
  logic [1:0]       wr_sel;
  logic [1:0]       rd_sel;
  logic             eoi_wr;
  logic             rd_ack;
  logic             eoi;

  // Scheduling datapath.
  logic [N_SRC-1:0] set;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] vec_oh;
  logic [VEC_W-1:0] pe_idx;
  logic             pe_any;
  logic             valid;

  // Byte offsets inside a word and data bits above the source count carry
  // no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{bus.wr_addr[1:0], bus.rd_addr[1:0],
                         bus.wr_data[31:N_SRC]};

  // ---------------------------------------------------------------------
  // Bus decode: only full-word writes are honoured, EOI included.
  // ---------------------------------------------------------------------
  assign wr_ok  = bus.wr_en && (bus.wr_strb == 4'b1111);
  assign wr_sel = bus.wr_addr[3:2];
  assign rd_sel = bus.rd_addr[3:2];
  assign eoi_wr = wr_ok && (wr_sel == IRQ_IVR);

`ifdef IRQ_SCHED_AUTOACK_EN
  // Reading the vector doubles as the acknowledge.
  assign rd_ack = bus.rd_en && (rd_sel == IRQ_IVR);
`else
  // Reads never have side effects.
  assign rd_ack = 1'b0;
`endif

  // An acknowledge only means something while a source is in service.
  assign eoi = (eoi_wr || rd_ack) && (state == ST_ACTIVE);

  // ---------------------------------------------------------------------
  // Pending logic
  // ---------------------------------------------------------------------
  // Edge sources pend on a rising edge, level sources whenever high.
  assign set = (src_in & ~src_d & EDGE_SRC) | (src_in & ~EDGE_SRC);

  // One-hot of the in-service source, used to retire it on EOI.
  assign vec_oh = N_SRC'(1) << vec;

  // Next pending vector: W1C and EOI clear, a fresh set always wins. EOI
  // clears the serviced bit for both modes; a level line that is still
  // high re-pends through set in that same cycle, a dropped one stays clear.
  always_comb begin
    ipr_n = ipr;
    if (wr_ok && (wr_sel == IRQ_IPR)) begin
      ipr_n = ipr_n & ~bus.wr_data[N_SRC-1:0];
    end
    if (eoi) begin
      ipr_n = ipr_n & ~vec_oh;
    end
    ipr_n = ipr_n | set;
  end

  // Register file, line history and the captured vector.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: everything here is a small flop, so all of it is reset; there
      // is no memory array whose contents could be left undefined.
      src_d <= '0;
      ier   <= '0;
      ipr   <= '0;
      vec   <= '0;
    end else begin
      src_d <= src_in;
      ipr   <= ipr_n;
      if (wr_ok && (wr_sel == IRQ_IER)) begin
        ier <= bus.wr_data[N_SRC-1:0];
      end
      if ((state == ST_IDLE) && pe_any) begin
        vec <= pe_idx;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Source selection
  // ---------------------------------------------------------------------
  assign cand = ipr & ier;

  prio_enc #(
    .N (N_SRC)
  ) u_prio_enc (
    .req (cand),
    .idx (pe_idx),
    .any (pe_any)
  );

  // ---------------------------------------------------------------------
  // Service FSM
  // ---------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state: enter service on any candidate, leave only on EOI. Leaving
  // always lands in IDLE for a cycle, which keeps irq_out low between
  // back-to-back services. Disabling the in-service source does not end it.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:   if (pe_any) state_n = ST_ACTIVE;
      ST_ACTIVE: if (eoi)    state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state flop, so irq_out comes straight off a
  // register with no combinational path from the inputs.
  always_comb begin
    valid   = (state == ST_ACTIVE);
    irq_out = valid;
  end

  // ---------------------------------------------------------------------
  // Read mux (combinational, zero when not reading)
  // ---------------------------------------------------------------------
  // Returns the selected register word; the IVR vector is the last one
  // captured and is only meaningful while valid is set.
  always_comb begin
    bus.rd_data = '0;
    if (bus.rd_en) begin
      unique case (rd_sel)
        IRQ_RAW: bus.rd_data = {{(32-N_SRC){1'b0}}, src_in};
        IRQ_IER: bus.rd_data = {{(32-N_SRC){1'b0}}, ier};
        IRQ_IPR: bus.rd_data = {{(32-N_SRC){1'b0}}, ipr};
        IRQ_IVR: bus.rd_data = ivr_word(valid, vec);
        default: bus.rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_sched.sv
// Self-checking bench for irq_sched (N_SRC=4, source 0 level, 1..3 edge).
// A cycle-level model of the register/service rules runs alongside the DUT
// and is compared every cycle; directed steps add literal expectations.
module tb_irq_sched;

`ifdef IRQ_SCHED_AUTOACK_EN
  localparam bit AUTOACK = 1'b1;
`else
  localparam bit AUTOACK = 1'b0;
`endif

  localparam logic [3:0] EDGE = 4'hE;

  logic       clk;
  logic       rst;
  logic [3:0] src_in;
  logic       irq_out;

  irq_sched_if bus ();

  irq_sched #(
    .N_SRC     (4),
    .EDGE_MASK (16'h000E)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .src_in  (src_in),
    .irq_out (irq_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] m_ier, m_ipr, m_prev, m_next;
  bit         m_act;
  int         m_vec;
  bit         model_ok = 1'b0;
  bit         m_wr_ok, m_eoi;

  always @(posedge clk) begin
    if (rst) begin
      m_ier = 0; m_ipr = 0; m_prev = 0; m_act = 0; m_vec = 0;
      model_ok = 1'b1;
    end else begin
      m_wr_ok = bus.wr_en && (bus.wr_strb == 4'hF);
      m_eoi   = m_act && ((m_wr_ok && bus.wr_addr[3:2] == 2'd3) ||
                          (AUTOACK && bus.rd_en && bus.rd_addr[3:2] == 2'd3));
      m_next = m_ipr;
      if (m_wr_ok && bus.wr_addr[3:2] == 2'd2) m_next = m_next & ~bus.wr_data[3:0];
      if (m_eoi) m_next[m_vec] = 1'b0;
      for (int i = 0; i < 4; i++)
        if (src_in[i] && !(EDGE[i] && m_prev[i])) m_next[i] = 1'b1;
      if (m_act) begin
        if (m_eoi) m_act = 0;
      end else begin
        for (int i = 0; i < 4; i++)
          if (!m_act && m_ipr[i] && m_ier[i]) begin
            m_act = 1; m_vec = i;
          end
      end
      if (m_wr_ok && bus.wr_addr[3:2] == 2'd1) m_ier = bus.wr_data[3:0];
      m_ipr  = m_next;
      m_prev = src_in;
    end
  end

  function automatic logic [31:0] model_rd();
    if (!bus.rd_en) return 32'h0;
    case (bus.rd_addr[3:2])
      2'd0:    return {28'h0, src_in};
      2'd1:    return {28'h0, m_ier};
      2'd2:    return {28'h0, m_ipr};
      default: return {m_act, 27'h0, m_vec[3:0]};
    endcase
  endfunction

  // Every-cycle comparison, mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check("cyc_irq", {31'h0, irq_out}, {31'h0, m_act});
      check("cyc_rd", bus.rd_data, model_rd());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    bus.wr_addr = a; bus.wr_data = d; bus.wr_strb = s; bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp,
                        input string name);
    bus.rd_addr = a; bus.rd_en = 1'b1;
    #1;
    check(name, bus.rd_data, exp);
    bus.rd_en = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; src_in = 4'h0;
    bus.wr_addr = 0; bus.wr_data = 0; bus.wr_strb = 0; bus.wr_en = 0;
    bus.rd_addr = 0; bus.rd_en = 0;
    tick(); tick();
    check("rst_irq", {31'h0, irq_out}, 32'h0);
    rd_chk(4'h4, 32'h0, "rst_ier");
    rd_chk(4'h8, 32'h0, "rst_ipr");
    rd_chk(4'hC, 32'h0, "rst_ivr");
    rst = 1'b0;

    // Single edge pulse on source 2.
    wr(4'h4, 32'h5, 4'hF);
    src_in = 4'b0100; tick(); src_in = 4'h0;
    rd_chk(4'h8, 32'h4, "t1_ipr");
    check("t1_irq_wait", {31'h0, irq_out}, 32'h0);
    tick();
    check("t1_irq_up", {31'h0, irq_out}, 32'h1);
    rd_chk(4'hC, 32'h8000_0002, "t1_ivr");
    wr(4'hC, 32'h0, 4'hF);
    check("t1_eoi_irq", {31'h0, irq_out}, 32'h0);
    rd_chk(4'h8, 32'h0, "t1_eoi_ipr");

    // Simultaneous edges on 1 and 3: priority then back-to-back.
    wr(4'h4, 32'hF, 4'hF);
    src_in = 4'b1010; tick(); src_in = 4'h0; tick();
    check("t2_irq", {31'h0, irq_out}, 32'h1);
    rd_chk(4'hC, 32'h8000_0001, "t2_ivr1");
    wr(4'hC, 32'h0, 4'hF);
    check("t2_gap", {31'h0, irq_out}, 32'h0);
    rd_chk(4'h8, 32'h8, "t2_ipr");
    tick();
    check("t2_irq3", {31'h0, irq_out}, 32'h1);
    rd_chk(4'hC, 32'h8000_0003, "t2_ivr3");

    // No preemption by source 0 while 3 is in service.
    src_in = 4'b0001; tick(); src_in = 4'h0; tick();
    rd_chk(4'hC, 32'h8000_0003, "t3_nopreempt");
    rd_chk(4'h8, 32'h9, "t3_ipr");
    wr(4'hC, 32'h0, 4'hF);
    check("t3_gap", {31'h0, irq_out}, 32'h0);
    tick();
    rd_chk(4'hC, 32'h8000_0000, "t3_ivr0");
    wr(4'hC, 32'h0, 4'hF); tick();
    check("t3_level_low", {31'h0, irq_out}, 32'h0);
    rd_chk(4'h8, 32'h0, "t3_ipr_clr");

    // Held level source re-pends after EOI; dropped one does not.
    src_in = 4'b0001; tick(); tick();
    check("t4_irq", {31'h0, irq_out}, 32'h1);
    rd_chk(4'h0, 32'h1, "t4_raw");
    wr(4'hC, 32'h0, 4'hF);
    check("t4_gap", {31'h0, irq_out}, 32'h0);
    tick();
    check("t4_repend", {31'h0, irq_out}, 32'h1);
    src_in = 4'h0; tick();
    wr(4'hC, 32'h0, 4'hF); tick();
    check("t4_drop", {31'h0, irq_out}, 32'h0);
    rd_chk(4'h8, 32'h0, "t4_ipr");

    // W1C vs set, strobes, unused bits, EOI in IDLE.
    wr(4'h4, 32'h0, 4'hF);
    src_in = 4'b0100; tick(); src_in = 4'h0; tick();
    src_in = 4'b0100; wr(4'h8, 32'h4, 4'hF); src_in = 4'h0;
    rd_chk(4'h8, 32'h4, "t5_set_wins");
    wr(4'h8, 32'h4, 4'hF);
    rd_chk(4'h8, 32'h0, "t5_w1c");
    tick(); src_in = 4'b0100; tick(); src_in = 4'h0;
    wr(4'h8, 32'h4, 4'b0011);
    rd_chk(4'h8, 32'h4, "t5_strb_ipr");
    wr(4'h4, 32'hF, 4'b0011);
    rd_chk(4'h4, 32'h0, "t5_strb_ier");
    wr(4'h4, 32'hFFFF_FFF2, 4'hF);
    rd_chk(4'h4, 32'h2, "t5_ier_upper");
    wr(4'hC, 32'h0, 4'hF);
    rd_chk(4'h8, 32'h4, "t5_eoi_idle");
    wr(4'h4, 32'h4, 4'hF);
    check("t5_ier_lat", {31'h0, irq_out}, 32'h0);
    tick();
    check("t5_irq", {31'h0, irq_out}, 32'h1);
    wr(4'hC, 32'h0, 4'b0111);
    check("t5_eoi_strb", {31'h0, irq_out}, 32'h1);
    src_in = 4'b0101;
    rd_chk(4'h0, 32'h5, "t5_raw");
    src_in = 4'h0;

    // IVR read across an edge: acknowledge only in the auto-ack build.
    bus.rd_addr = 4'hC; bus.rd_en = 1'b1;
    #1;
    check("t6_ivr", bus.rd_data, 32'h8000_0002);
    tick();
    bus.rd_en = 1'b0;
    check("t6_autoack", {31'h0, irq_out}, AUTOACK ? 32'h0 : 32'h1);
    if (!AUTOACK) wr(4'hC, 32'h0, 4'hF);
    check("t6_after", {31'h0, irq_out}, 32'h0);

    // Reset in the middle of a service.
    wr(4'h4, 32'hF, 4'hF);
    src_in = 4'b0010; tick(); src_in = 4'h0; tick();
    check("t7_irq", {31'h0, irq_out}, 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t7_irq_rst", {31'h0, irq_out}, 32'h0);
    rd_chk(4'h4, 32'h0, "t7_ier");
    rd_chk(4'h8, 32'h0, "t7_ipr");
    rd_chk(4'hC, 32'h0, "t7_ivr");
    tick();
    check("t7_idle", {31'h0, irq_out}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
